// File: rtl/tlul_mem_slave_if.sv
// TL-UL A/D channel bundle between tlul_master and tlul_mem_slave.
// Ports (signals):
//   a_valid, a_ready, a_opcode, a_size, a_address, a_mask, a_data  -- Channel A
//   d_valid, d_ready, d_opcode, d_size, d_data                     -- Channel D
//   d_error  -- only when TLUL_MEM_SLAVE_ERR_EN is defined
// Modports: master (drives A, accepts D), slave (accepts A, drives D).
interface tlul_mem_slave_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH/8,
  parameter int SIZE_WIDTH   = 3,
  parameter int OPCODE_WIDTH = 3
);
  logic                    a_valid;
  logic                    a_ready;
  logic [OPCODE_WIDTH-1:0] a_opcode;
  logic [SIZE_WIDTH-1:0]   a_size;
  logic [ADDR_WIDTH-1:0]   a_address;
  logic [MASK_WIDTH-1:0]   a_mask;
  logic [DATA_WIDTH-1:0]   a_data;
  logic                    d_valid;
  logic                    d_ready;
  logic [OPCODE_WIDTH-1:0] d_opcode;
  logic [SIZE_WIDTH-1:0]   d_size;
  logic [DATA_WIDTH-1:0]   d_data;
`ifdef TLUL_MEM_SLAVE_ERR_EN
  logic                    d_error;
`endif

  modport master (
    output a_valid, a_opcode, a_size, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_size, d_data
`ifdef TLUL_MEM_SLAVE_ERR_EN
    , input d_error
`endif
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_size, d_data
`ifdef TLUL_MEM_SLAVE_ERR_EN
    , output d_error
`endif
  );
endinterface

// File: rtl/tlul_mem_slave.sv
// TL-UL slave endpoint backed by a DEPTH-word byte-maskable register file.
// One outstanding transaction; response appears RESP_LAT cycles after accept.
// Ports:
//   clk_24  -- sole clock
//   rst_n   -- asynchronous active-low reset
//   bus     -- tlul_mem_slave_if.slave (Channel A in, Channel D out)
// Optional feature: define TLUL_MEM_SLAVE_ERR_EN to add d_error and
// range/opcode checking. Undefined: addresses wrap modulo DEPTH words and
// unsupported opcodes are acked without side effects.
module tlul_mem_slave #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH/8,
  parameter int SIZE_WIDTH   = 3,
  parameter int OPCODE_WIDTH = 3,
  parameter int DEPTH        = 256,
  parameter int RESP_LAT     = 2
) (
  input  logic              clk_24,
  input  logic              rst_n,
  tlul_mem_slave_if.slave   bus
);

  localparam int OFF = $clog2(MASK_WIDTH);
  localparam int IW  = $clog2(DEPTH);
  localparam int CW  = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [OPCODE_WIDTH-1:0] OP_GET  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACKD = OPCODE_WIDTH'(4);

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [1:0]              state;
  logic                    a_ready_q;
  logic [CW-1:0]           cnt;
  logic [OPCODE_WIDTH-1:0] lat_op;
  logic [SIZE_WIDTH-1:0]   lat_size;
  logic [IW-1:0]           lat_idx;
  logic                    lat_err;

  logic                    d_valid_q;
  logic [OPCODE_WIDTH-1:0] d_opcode_q;
  logic [SIZE_WIDTH-1:0]   d_size_q;
  logic [DATA_WIDTH-1:0]   d_data_q;
  logic                    d_error_q;

  logic                    accept;
  logic [IW-1:0]           in_idx;
  logic                    in_err;
  logic                    wr_en;
  logic [OPCODE_WIDTH-1:0] r_op;
  logic [SIZE_WIDTH-1:0]   r_size;
  logic [IW-1:0]           r_idx;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign accept = (state == S_IDLE) && a_ready_q && bus.a_valid;
  assign in_idx = bus.a_address[OFF +: IW];

`ifdef TLUL_MEM_SLAVE_ERR_EN
  // Any address bit above the word index means address >= DEPTH*MASK_WIDTH.
  assign in_err = (|bus.a_address[ADDR_WIDTH-1:OFF+IW]) ||
                  !((bus.a_opcode == OP_GET) || (bus.a_opcode == OP_PUT));
`else
  assign in_err = 1'b0;
`endif

  assign wr_en = accept && (bus.a_opcode == OP_PUT) && !in_err;

  // With RESP_LAT==1 the response is built at the accept edge, so the
  // request fields come straight off the bus instead of the latches.
  assign r_op    = (state == S_IDLE) ? bus.a_opcode : lat_op;
  assign r_size  = (state == S_IDLE) ? bus.a_size   : lat_size;
  assign r_idx   = (state == S_IDLE) ? in_idx       : lat_idx;
  assign r_err   = (state == S_IDLE) ? in_err       : lat_err;
  assign rd_word = mem[r_idx];

  // Memory has no reset; a write lands on the accept edge.
  always_ff @(posedge clk_24) begin
    if (wr_en) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (bus.a_mask[b]) mem[in_idx][b*8 +: 8] <= bus.a_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      a_ready_q  <= 1'b0;
      cnt        <= '0;
      lat_op     <= '0;
      lat_size   <= '0;
      lat_idx    <= '0;
      lat_err    <= 1'b0;
      d_valid_q  <= 1'b0;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_ready_q <= 1'b0;
            lat_op    <= bus.a_opcode;
            lat_size  <= bus.a_size;
            lat_idx   <= in_idx;
            lat_err   <= in_err;
            if (RESP_LAT == 1) begin
              state      <= S_RESP;
              d_valid_q  <= 1'b1;
              d_opcode_q <= (r_op == OP_GET) ? OP_ACKD : OP_ACK;
              d_size_q   <= r_size;
              d_data_q   <= ((r_op == OP_GET) && !r_err) ? rd_word : '0;
              d_error_q  <= r_err;
            end else begin
              state <= S_WAIT;
              cnt   <= CW'(RESP_LAT - 2);
            end
          end else begin
            // Registered: first IDLE cycle after reset/handshake has a_ready=0.
            a_ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            // Read happens here so an earlier accepted write is visible.
            state      <= S_RESP;
            d_valid_q  <= 1'b1;
            d_opcode_q <= (r_op == OP_GET) ? OP_ACKD : OP_ACK;
            d_size_q   <= r_size;
            d_data_q   <= ((r_op == OP_GET) && !r_err) ? rd_word : '0;
            d_error_q  <= r_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (bus.d_ready) begin
            d_valid_q <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.a_ready  = a_ready_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.d_opcode = d_opcode_q;
  assign bus.d_size   = d_size_q;
  assign bus.d_data   = d_data_q;
`ifdef TLUL_MEM_SLAVE_ERR_EN
  assign bus.d_error  = d_error_q;
`else
  logic unused_err;
  assign unused_err = d_error_q;
`endif

endmodule
